// File: rtl/stall_control_block.sv
// Hazard/stall generator for the 16-bit MIPS decode stage: halt, load-use and jump stalls.
// Optional saturating stall counter enabled by defining STALL_CNT_EN.
module stall_control_block #(
  parameter logic [5:0] OP_HLT = 6'b010001,
  parameter logic [5:0] OP_LD  = 6'b010100,
  parameter logic [5:0] OP_JMP = 6'b011110
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  output logic        stall,
`ifdef STALL_CNT_EN
  output logic [15:0] stall_cnt,
`endif
  output logic        stall_pm
);

  logic hlt;
  logic ld;
  logic jmp;

  logic ld_q,       ld_d;
  logic jmp1_q,     jmp1_d;
  logic jmp2_q,     jmp2_d;
  logic stall_pm_q, stall_pm_d;

  // A load stalls once; a jump stalls twice, suppressed while its history reaches the second stage.
  always_comb begin
    hlt        = (op == OP_HLT);
    ld         = (op == OP_LD) & ~ld_q;
    jmp        = (op == OP_JMP) & ~jmp2_q;
    stall      = reset & (hlt | ld | jmp);
    ld_d       = ld;
    jmp1_d     = jmp;
    jmp2_d     = jmp1_q;
    stall_pm_d = stall;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ld_q       <= 1'b0;
      jmp1_q     <= 1'b0;
      jmp2_q     <= 1'b0;
      stall_pm_q <= 1'b0;
    end else begin
      ld_q       <= ld_d;
      jmp1_q     <= jmp1_d;
      jmp2_q     <= jmp2_d;
      stall_pm_q <= stall_pm_d;
    end
  end

  assign stall_pm = stall_pm_q;

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Saturates at all-ones rather than wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_stall_control_block.sv
// Directed self-checking bench for stall_control_block; define STALL_CNT_EN to also check the counter.
module tb_stall_control_block;

  localparam logic [5:0] OP_HLT = 6'b010001;
  localparam logic [5:0] OP_LD  = 6'b010100;
  localparam logic [5:0] OP_JMP = 6'b011110;
  localparam logic [5:0] OP_NOP = 6'b000000;

  logic        clk;
  logic        reset;
  logic [5:0]  op;
  logic        stall;
  logic        stall_pm;
`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int compared;
  int mismatched;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  stall_control_block dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .stall    (stall),
`ifdef STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .stall_pm (stall_pm)
  );

  // Driver: apply one cycle's inputs mid-cycle, then settle before sampling.
  task automatic drive(input logic [5:0] o, input logic r);
    @(negedge clk);
    op    = o;
    reset = r;
    #1;
  endtask

  task automatic test_reset();
    // Reset low with halt present must still give stall=0.
    logic [5:0] ops [3] = '{OP_NOP, OP_HLT, OP_NOP};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b0);
      if (i > 0) begin
        compared++;
        if (stall !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_stall cyc%0d: got %b want 0", i, stall);
        end
        compared++;
        if (stall_pm !== 1'b0) begin
          mismatched++;
          $display("FAIL reset_stall_pm cyc%0d: got %b want 0", i, stall_pm);
        end
`ifdef STALL_CNT_EN
        compared++;
        if (stall_cnt !== 16'd0) begin
          mismatched++;
          $display("FAIL reset_cnt cyc%0d: got %0d want 0", i, stall_cnt);
        end
`endif
      end
    end
  endtask

  task automatic test_load();
    logic [5:0] ops    [3] = '{OP_LD, OP_LD, OP_NOP};
    logic       exp_s  [3] = '{1'b1, 1'b0, 1'b0};
    logic       exp_pm [3] = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b1);
      compared++;
      if (stall !== exp_s[i]) begin
        mismatched++;
        $display("FAIL load_stall cyc%0d: got %b want %b", i, stall, exp_s[i]);
      end
      compared++;
      if (stall_pm !== exp_pm[i]) begin
        mismatched++;
        $display("FAIL load_stall_pm cyc%0d: got %b want %b", i, stall_pm, exp_pm[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [5:0] ops    [4] = '{OP_JMP, OP_JMP, OP_JMP, OP_NOP};
    logic       exp_s  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_pm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b1);
      compared++;
      if (stall !== exp_s[i]) begin
        mismatched++;
        $display("FAIL jump_stall cyc%0d: got %b want %b", i, stall, exp_s[i]);
      end
      compared++;
      if (stall_pm !== exp_pm[i]) begin
        mismatched++;
        $display("FAIL jump_stall_pm cyc%0d: got %b want %b", i, stall_pm, exp_pm[i]);
      end
    end
  endtask

  task automatic test_halt();
    logic [5:0] ops    [5] = '{OP_HLT, OP_HLT, OP_HLT, OP_HLT, OP_NOP};
    logic       exp_s  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       exp_pm [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 1'b1);
      compared++;
      if (stall !== exp_s[i]) begin
        mismatched++;
        $display("FAIL halt_stall cyc%0d: got %b want %b", i, stall, exp_s[i]);
      end
      compared++;
      if (stall_pm !== exp_pm[i]) begin
        mismatched++;
        $display("FAIL halt_stall_pm cyc%0d: got %b want %b", i, stall_pm, exp_pm[i]);
      end
    end
`ifdef STALL_CNT_EN
    // load 1 + jump 2 + halt 4
    compared++;
    if (stall_cnt !== 16'd7) begin
      mismatched++;
      $display("FAIL cnt_after_seq: got %0d want 7", stall_cnt);
    end
`endif
  endtask

  task automatic test_other_op();
    logic [5:0] ops [4] = '{6'h3F, 6'h10, 6'b010101, 6'b011111};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b1);
      compared++;
      if (stall !== 1'b0) begin
        mismatched++;
        $display("FAIL other_op_stall op=%h: got %b want 0", ops[i], stall);
      end
    end
  endtask

  task automatic test_jump_then_load();
    logic [5:0] ops    [4] = '{OP_JMP, OP_LD, OP_LD, OP_NOP};
    logic       exp_s  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_pm [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], 1'b1);
      compared++;
      if (stall !== exp_s[i]) begin
        mismatched++;
        $display("FAIL jmp_ld_stall cyc%0d: got %b want %b", i, stall, exp_s[i]);
      end
      compared++;
      if (stall_pm !== exp_pm[i]) begin
        mismatched++;
        $display("FAIL jmp_ld_stall_pm cyc%0d: got %b want %b", i, stall_pm, exp_pm[i]);
      end
    end
    // let the jump history drain
    drive(OP_NOP, 1'b1);
    drive(OP_NOP, 1'b1);
  endtask

  task automatic test_reset_mid_jump();
    logic [5:0] ops    [6] = '{OP_JMP, OP_JMP, OP_JMP, OP_JMP, OP_JMP, OP_NOP};
    logic       rst    [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       exp_s  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       exp_pm [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], rst[i]);
      compared++;
      if (stall !== exp_s[i]) begin
        mismatched++;
        $display("FAIL rst_mid_stall cyc%0d: got %b want %b", i, stall, exp_s[i]);
      end
      compared++;
      if (stall_pm !== exp_pm[i]) begin
        mismatched++;
        $display("FAIL rst_mid_stall_pm cyc%0d: got %b want %b", i, stall_pm, exp_pm[i]);
      end
`ifdef STALL_CNT_EN
      if (i == 2) begin
        compared++;
        if (stall_cnt !== 16'd0) begin
          mismatched++;
          $display("FAIL rst_mid_cnt_clear: got %0d want 0", stall_cnt);
        end
      end
`endif
    end
`ifdef STALL_CNT_EN
    compared++;
    if (stall_cnt !== 16'd2) begin
      mismatched++;
      $display("FAIL rst_mid_cnt: got %0d want 2", stall_cnt);
    end
`endif
  endtask

`ifdef STALL_CNT_EN
  task automatic test_cnt_saturate();
    drive(OP_NOP, 1'b0);
    repeat (65534) drive(OP_HLT, 1'b1);
    drive(OP_NOP, 1'b1);
    compared++;
    if (stall_cnt !== 16'hFFFE) begin
      mismatched++;
      $display("FAIL cnt_near_max: got %h want fffe", stall_cnt);
    end
    drive(OP_HLT, 1'b1);
    drive(OP_HLT, 1'b1);
    compared++;
    if (stall_cnt !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL cnt_max: got %h want ffff", stall_cnt);
    end
    repeat (3) drive(OP_HLT, 1'b1);
    compared++;
    if (stall_cnt !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL cnt_saturate: got %h want ffff", stall_cnt);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    op         = OP_NOP;
    test_reset();
    test_load();
    test_jump();
    test_halt();
    test_other_op();
    test_jump_then_load();
    test_reset_mid_jump();
`ifdef STALL_CNT_EN
    test_cnt_saturate();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
